// File: rtl/instr_prefetch_unit.sv
// Instruction prefetch unit: credit-limited in-order fetch into a DEPTH-entry {pc, instr} buffer.
// Latency: request the cycle after reset/redirect; response visible to decode one cycle after imem_rvalid.
// Backpressure: out_ready low stalls decode; fetch stops once outstanding + buffered reaches DEPTH.

// Generic synchronous FIFO with flush; no bypass, head is registered storage.
// Latency: pushed word visible at pop side one cycle after the push edge.
// Backpressure: push_rdy low when full; pop_vld low when empty.
module instr_prefetch_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push_vld,
  output logic                     push_rdy,
  input  logic [W-1:0]             push_dat,
  output logic                     pop_vld,
  input  logic                     pop_rdy,
  output logic [W-1:0]             pop_dat,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  logic [W-1:0]    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CNTW-1:0] cnt;
  logic            do_push;
  logic            do_pop;

  assign push_rdy = (cnt != CNTW'(DEPTH));
  assign pop_vld  = (cnt != '0);
  assign pop_dat  = mem[rd_ptr];
  assign count    = cnt;
  assign do_push  = push_vld & push_rdy;
  assign do_pop   = pop_vld & pop_rdy;

  // Pointer/occupancy update; flush empties the queue and beats any push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CNTW'(do_push) - CNTW'(do_pop);
    end
  end

  // Storage; cleared on reset so the head reads as zero while the block is held in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push && !flush) begin
      mem[wr_ptr] <= push_dat;
    end
  end

endmodule

module instr_prefetch_unit #(
  parameter int              PC_W     = 32,
  parameter int              INSTR_W  = 32,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc
);

  // Counters must hold 2*DEPTH: outstanding + buffered never exceeds that sum.
  localparam int CW = $clog2(2 * DEPTH) + 1;
  localparam int FW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic [PC_W-1:0] fetch_pc;     // address of the next request to issue
  logic [PC_W-1:0] rsp_pc;       // address belonging to the next non-discarded response
  logic [CW-1:0]   outstanding;  // issued, not yet returned, still wanted
  logic [CW-1:0]   drop;         // stale responses still to be swallowed
  logic [CW-1:0]   credit_used;
  logic [FW-1:0]   fifo_count;
  logic [PC_W-1:0] redir_pc;

  logic   issue;
  logic   rsp_live;
  logic   rsp_take;
  logic   rsp_drop;
  logic   fifo_push_vld;
  logic   fifo_push_rdy;
  logic   fifo_pop_rdy;
  entry_t fifo_push_dat;
  entry_t head;

  // Word-align the redirect target; the low two address bits are never fetched.
  assign redir_pc = redirect_pc & ~PC_W'(3);

  assign credit_used = outstanding + CW'(fifo_count);

  // Request only with a free credit and never in a redirect cycle; held low while in reset.
  assign imem_req  = rst_n & ~redirect_valid & (credit_used < CW'(DEPTH));
  assign imem_addr = fetch_pc;
  assign issue     = imem_req & imem_ready;

  // A response is meaningful only if something is in flight; otherwise it is spurious and ignored.
  assign rsp_live = imem_rvalid & ((drop != '0) | (outstanding != '0));
  assign rsp_drop = imem_rvalid & (drop != '0);
  assign rsp_take = imem_rvalid & (drop == '0) & (outstanding != '0);

  assign fifo_push_vld       = rsp_take & ~redirect_valid & fifo_push_rdy;
  assign fifo_push_dat.pc    = rsp_pc;
  assign fifo_push_dat.instr = imem_rdata;
  assign fifo_pop_rdy        = out_ready & ~redirect_valid;

  instr_prefetch_fifo #(
    .W     (PC_W + INSTR_W),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect_valid),
    .push_vld (fifo_push_vld),
    .push_rdy (fifo_push_rdy),
    .push_dat (fifo_push_dat),
    .pop_vld  (out_valid),
    .pop_rdy  (fifo_pop_rdy),
    .pop_dat  (head),
    .count    (fifo_count)
  );

  assign out_pc    = head.pc;
  assign out_instr = head.instr;

  // Fetch address: restart at the aligned target on redirect, otherwise step one word per accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= redir_pc;
    end else if (issue) begin
      fetch_pc <= fetch_pc + PC_W'(4);
    end
  end

  // Response tag: responses return in order, so the pc of the next kept response just counts up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_pc <= RESET_PC;
    end else if (redirect_valid) begin
      rsp_pc <= redir_pc;
    end else if (fifo_push_vld) begin
      rsp_pc <= rsp_pc + PC_W'(4);
    end
  end

  // In-flight bookkeeping; on redirect every wanted request becomes stale, including one returning now.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
      drop        <= '0;
    end else if (redirect_valid) begin
      outstanding <= '0;
      drop        <= drop + outstanding - CW'(rsp_live);
    end else begin
      outstanding <= outstanding + CW'(issue) - CW'(rsp_take);
      drop        <= drop - CW'(rsp_drop);
    end
  end

  // Credit accounting guarantees every kept response finds a free slot.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    (rsp_take && !redirect_valid) |-> fifo_push_rdy);

  // A request waiting on imem_ready keeps its address.
  a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (imem_req && !imem_ready) |=> $stable(imem_addr));

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Directed bench for instr_prefetch_unit with an in-order, fixed-latency memory model.
// Latency of the model is set per scenario; responses can be delayed to keep requests in flight.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_instr_prefetch_unit;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;
  localparam int DEPTH   = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ready;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [PC_W-1:0]    out_pc;

  instr_prefetch_unit #(
    .PC_W     (PC_W),
    .INSTR_W  (INSTR_W),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int lat   = 1;

  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] issued[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_ins[$];
  int          pop_cyc[$];

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  // One clock: drive memory response, log accepted requests and pops, advance to the next falling edge.
  task automatic tick();
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = data_of(pend_addr[0]);
      pend_addr.delete(0);
      pend_due.delete(0);
    end
    #1;
    if (rst_n && imem_req && imem_ready) begin
      pend_addr.push_back(imem_addr);
      pend_due.push_back(cyc + lat);
      issued.push_back(imem_addr);
    end
    if (rst_n && out_valid && out_ready && !redirect_valid) begin
      pop_pc.push_back(out_pc);
      pop_ins.push_back(out_instr);
      pop_cyc.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    pend_addr.delete();
    pend_due.delete();
    issued.delete();
    pop_pc.delete();
    pop_ins.delete();
    pop_cyc.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_imem_req: got %b want 0", imem_req); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_vec++; if (out_instr !== 32'h0) begin n_err++; $display("FAIL reset_out_instr: got %h want 0", out_instr); end
    n_vec++; if (out_pc !== 32'h0) begin n_err++; $display("FAIL reset_out_pc: got %h want 0", out_pc); end
    rst_n = 1'b1;
    cyc   = 0;
    #1;
    n_vec++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL release_imem_req: got %b want 1", imem_req); end
    n_vec++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL release_imem_addr: got %h want 0", imem_addr); end
  endtask

  // Continues straight from reset release: 1-cycle memory, decode always ready.
  task automatic test_stream();
    logic [31:0] exp_pc[$];
    exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC};
    lat = 1; imem_ready = 1'b1; out_ready = 1'b1;
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_no_early_valid: got %b want 0", out_valid); end
    tick();
    n_vec++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin n_err++; $display("FAIL stream_first_valid: got v=%b pc=%h want v=1 pc=0", out_valid, out_pc); end
    for (int i = 0; i < 6; i++) tick();
    for (int i = 0; i < exp_pc.size(); i++) begin
      n_vec++;
      if (i >= pop_pc.size()) begin
        n_err++; $display("FAIL stream_pop%0d: got nothing want pc %h", i, exp_pc[i]);
      end else if (pop_pc[i] !== exp_pc[i] || pop_ins[i] !== data_of(exp_pc[i]) || pop_cyc[i] != 2 + i) begin
        n_err++; $display("FAIL stream_pop%0d: got pc %h instr %h cyc %0d want pc %h instr %h cyc %0d",
                          i, pop_pc[i], pop_ins[i], pop_cyc[i], exp_pc[i], data_of(exp_pc[i]), 2 + i);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_pc[$];
    exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    do_reset();
    lat = 1; imem_ready = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i >= 1) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== data_of(32'h0)) begin
          n_err++; $display("FAIL stall_hold_c%0d: got v=%b pc=%h instr=%h want v=1 pc=0 instr=%h",
                            i + 1, out_valid, out_pc, out_instr, data_of(32'h0));
        end
      end
    end
    n_vec++; if (issued.size() != DEPTH) begin n_err++; $display("FAIL stall_req_count: got %0d want %0d", issued.size(), DEPTH); end
    for (int i = 0; i < issued.size() && i < DEPTH; i++) begin
      n_vec++;
      if (issued[i] !== 32'(4 * i)) begin n_err++; $display("FAIL stall_req_addr%0d: got %h want %h", i, issued[i], 4 * i); end
    end
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL stall_req_off: got %b want 0", imem_req); end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    for (int i = 0; i < exp_pc.size(); i++) begin
      n_vec++;
      if (i >= pop_pc.size()) begin
        n_err++; $display("FAIL stall_pop%0d: got nothing want pc %h", i, exp_pc[i]);
      end else if (pop_pc[i] !== exp_pc[i] || pop_ins[i] !== data_of(exp_pc[i])) begin
        n_err++; $display("FAIL stall_pop%0d: got pc %h instr %h want pc %h instr %h",
                          i, pop_pc[i], pop_ins[i], exp_pc[i], data_of(exp_pc[i]));
      end
    end
  endtask

  // Two requests outstanding behind a slow memory when the redirect lands.
  task automatic test_redirect();
    logic [31:0] exp_pc[$];
    exp_pc = '{32'h40, 32'h44};
    do_reset();
    lat = 4; imem_ready = 1'b1; out_ready = 1'b1;
    tick();
    tick();
    n_vec++; if (issued.size() != 2) begin n_err++; $display("FAIL redirect_inflight: got %0d want 2", issued.size()); end
    redirect_pc = 32'h40; redirect_valid = 1'b1;
    #1;
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL redirect_no_req: got %b want 0", imem_req); end
    tick();
    redirect_valid = 1'b0;
    #1;
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin n_err++; $display("FAIL redirect_first_req: got req=%b addr=%h want req=1 addr=40", imem_req, imem_addr); end
    pop_pc.delete(); pop_ins.delete(); pop_cyc.delete();
    for (int i = 0; i < 14; i++) tick();
    for (int i = 0; i < exp_pc.size(); i++) begin
      n_vec++;
      if (i >= pop_pc.size()) begin
        n_err++; $display("FAIL redirect_pop%0d: got nothing want pc %h", i, exp_pc[i]);
      end else if (pop_pc[i] !== exp_pc[i] || pop_ins[i] !== data_of(exp_pc[i])) begin
        n_err++; $display("FAIL redirect_pop%0d: got pc %h instr %h want pc %h instr %h",
                          i, pop_pc[i], pop_ins[i], exp_pc[i], data_of(exp_pc[i]));
      end
    end
  endtask

  // Redirects during a 1-cycle stream: a response lands in each redirect cycle and must be discarded.
  task automatic test_misaligned_wrap();
    logic [31:0] exp_a[$];
    logic [31:0] exp_b[$];
    exp_a = '{32'h40, 32'h44};
    exp_b = '{32'hFFFF_FFFC, 32'h0000_0000};
    do_reset();
    lat = 1; imem_ready = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    redirect_pc = 32'h43; redirect_valid = 1'b1;
    tick();
    redirect_valid = 1'b0;
    #1;
    n_vec++; if (imem_addr !== 32'h40 || imem_req !== 1'b1) begin n_err++; $display("FAIL misaligned_addr: got req=%b addr=%h want req=1 addr=40", imem_req, imem_addr); end
    pop_pc.delete(); pop_ins.delete(); pop_cyc.delete();
    for (int i = 0; i < 6; i++) tick();
    for (int i = 0; i < exp_a.size(); i++) begin
      n_vec++;
      if (i >= pop_pc.size()) begin
        n_err++; $display("FAIL misaligned_pop%0d: got nothing want pc %h", i, exp_a[i]);
      end else if (pop_pc[i] !== exp_a[i] || pop_ins[i] !== data_of(exp_a[i])) begin
        n_err++; $display("FAIL misaligned_pop%0d: got pc %h instr %h want pc %h instr %h",
                          i, pop_pc[i], pop_ins[i], exp_a[i], data_of(exp_a[i]));
      end
    end
    redirect_pc = 32'hFFFF_FFFC; redirect_valid = 1'b1;
    tick();
    redirect_valid = 1'b0;
    #1;
    n_vec++; if (imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_addr: got %h want fffffffc", imem_addr); end
    pop_pc.delete(); pop_ins.delete(); pop_cyc.delete();
    for (int i = 0; i < 6; i++) tick();
    for (int i = 0; i < exp_b.size(); i++) begin
      n_vec++;
      if (i >= pop_pc.size()) begin
        n_err++; $display("FAIL wrap_pop%0d: got nothing want pc %h", i, exp_b[i]);
      end else if (pop_pc[i] !== exp_b[i] || pop_ins[i] !== data_of(exp_b[i])) begin
        n_err++; $display("FAIL wrap_pop%0d: got pc %h instr %h want pc %h instr %h",
                          i, pop_pc[i], pop_ins[i], exp_b[i], data_of(exp_b[i]));
      end
    end
  endtask

  // Reset lands between edges with one entry buffered and three requests outstanding.
  task automatic test_async_reset();
    logic [31:0] exp_pc[$];
    exp_pc = '{32'h0, 32'h4};
    do_reset();
    lat = 3; imem_ready = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    n_vec++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin n_err++; $display("FAIL areset_pre: got v=%b pc=%h want v=1 pc=0", out_valid, out_pc); end
    n_vec++; if (issued.size() != 4) begin n_err++; $display("FAIL areset_issued: got %0d want 4", issued.size()); end
    #2;
    rst_n = 1'b0;
    imem_rvalid = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL areset_out_valid: got %b want 0", out_valid); end
    n_vec++; if (out_pc !== 32'h0 || out_instr !== 32'h0) begin n_err++; $display("FAIL areset_out_data: got pc=%h instr=%h want 0 0", out_pc, out_instr); end
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL areset_imem_req: got %b want 0", imem_req); end
    @(negedge clk);
    @(negedge clk);
    imem_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_err++; $display("FAIL areset_release: got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++;
      if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
        n_err++; $display("FAIL areset_stale%0d: got v=%b req=%b addr=%h want v=0 req=1 addr=0", i, out_valid, imem_req, imem_addr);
      end
    end
    pend_addr.delete(); pend_due.delete();
    pop_pc.delete(); pop_ins.delete(); pop_cyc.delete();
    lat = 1; imem_ready = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    for (int i = 0; i < exp_pc.size(); i++) begin
      n_vec++;
      if (i >= pop_pc.size()) begin
        n_err++; $display("FAIL areset_pop%0d: got nothing want pc %h", i, exp_pc[i]);
      end else if (pop_pc[i] !== exp_pc[i] || pop_ins[i] !== data_of(exp_pc[i])) begin
        n_err++; $display("FAIL areset_pop%0d: got pc %h instr %h want pc %h instr %h",
                          i, pop_pc[i], pop_ins[i], exp_pc[i], data_of(exp_pc[i]));
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_misaligned_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

endmodule
